// File: rtl/rv_decode_stage.sv
// RV32I decode stage between fetch and execute.
// Decodes one instruction per cycle into the ALU operation and operands, plus memory, branch,
// jump and writeback control. The result sits in a single-entry output register behind a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  kill the held entry; blocks accept this cycle
//   in_valid / in_ready    input handshake for instr, pc, rs1_data, rs2_data
//   instr, pc              instruction word and its address
//   rs1_data, rs2_data     register-file read data, same cycle as instr
//   out_valid / out_ready  output handshake toward execute
//   alu_sel, alu_a, alu_b  ALU operation and operands
//   store_data             rs2_data for stores, else 0
//   rd, reg_write          writeback destination and enable
//   mem_read, mem_write    load / store
//   funct3                 instr[14:12] (memory size, branch sense)
//   branch, jump, target   control-flow class and target address
//   illegal                unsupported encoding
module rv_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      funct3,
  output logic            branch,
  output logic            jump,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSll  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluSlt  = 4'b1001,
    AluSltu = 4'b1010,
    AluZero = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  // Base operation shared by OP and OP-IMM for funct7 == 0.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    unique case (f3)
      3'b000:  base_op = AluAdd;
      3'b001:  base_op = AluSll;
      3'b010:  base_op = AluSlt;
      3'b011:  base_op = AluSltu;
      3'b100:  base_op = AluXor;
      3'b101:  base_op = AluSrl;
      3'b110:  base_op = AluOr;
      default: base_op = AluAnd;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, sh_rs2, sh_imm;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd_f   = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  // The ALU shifts by its whole operand, so only the low five bits may reach it.
  assign sh_rs2 = {27'b0, rs2_data[4:0]};
  assign sh_imm = {27'b0, instr[24:20]};

  alu_op_e     sel_d;
  logic [31:0] a_d, b_d, sd_d, tgt_d;
  logic [4:0]  rd_d;
  logic        rw_d, mr_d, mw_d, br_d, jp_d, legal;

  always_comb begin
    sel_d = AluAdd;
    a_d   = '0;
    b_d   = '0;
    sd_d  = '0;
    tgt_d = '0;
    rd_d  = rd_f;
    rw_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    br_d  = 1'b0;
    jp_d  = 1'b0;
    legal = 1'b1;
    unique case (opcode)
      OpcOp: begin
        a_d  = rs1_data;
        b_d  = (f3 == 3'b001 || f3 == 3'b101) ? sh_rs2 : rs2_data;
        rw_d = 1'b1;
        if (f7 == 7'b0000000) begin
          sel_d = base_op(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          sel_d = AluSub;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          sel_d = AluSra;
        end else begin
          legal = 1'b0;
        end
      end
      OpcOpImm: begin
        a_d   = rs1_data;
        b_d   = imm_i;
        rw_d  = 1'b1;
        sel_d = base_op(f3);
        if (f3 == 3'b001) begin
          b_d   = sh_imm;
          legal = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          b_d   = sh_imm;
          sel_d = f7[5] ? AluSra : AluSrl;
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end
      end
      OpcLui: begin
        b_d  = imm_u;
        rw_d = 1'b1;
      end
      OpcAuipc: begin
        a_d  = pc;
        b_d  = imm_u;
        rw_d = 1'b1;
      end
      OpcLoad: begin
        a_d   = rs1_data;
        b_d   = imm_i;
        mr_d  = 1'b1;
        rw_d  = 1'b1;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OpcStore: begin
        a_d   = rs1_data;
        b_d   = imm_s;
        sd_d  = rs2_data;
        mw_d  = 1'b1;
        rd_d  = '0;
        legal = (f3 < 3'b011);
      end
      OpcBranch: begin
        a_d   = rs1_data;
        b_d   = rs2_data;
        br_d  = 1'b1;
        rd_d  = '0;
        tgt_d = pc + imm_b;
        legal = (f3[2:1] != 2'b01);
        unique case (f3[2:1])
          2'b00:   sel_d = AluSub;
          2'b10:   sel_d = AluSlt;
          default: sel_d = AluSltu;
        endcase
      end
      OpcJal: begin
        a_d   = pc;
        b_d   = 32'd4;
        jp_d  = 1'b1;
        rw_d  = 1'b1;
        tgt_d = pc + imm_j;
      end
      OpcJalr: begin
        a_d   = pc;
        b_d   = 32'd4;
        jp_d  = 1'b1;
        rw_d  = 1'b1;
        tgt_d = (rs1_data + imm_i) & ~32'd1;
        legal = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries still flow to execute, but with every side effect suppressed.
    if (!legal) begin
      sel_d = AluZero;
      a_d   = '0;
      b_d   = '0;
      sd_d  = '0;
      tgt_d = '0;
      rd_d  = '0;
      rw_d  = 1'b0;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      br_d  = 1'b0;
      jp_d  = 1'b0;
    end
    if (rd_d == 5'd0) rw_d = 1'b0;
  end

  logic valid_q, valid_d, accept;

  assign in_ready  = !flush && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      store_data <= '0;
      rd         <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      funct3     <= '0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      target     <= '0;
      illegal    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        alu_sel    <= sel_d;
        alu_a      <= a_d;
        alu_b      <= b_d;
        store_data <= sd_d;
        rd         <= rd_d;
        reg_write  <= rw_d;
        mem_read   <= mr_d;
        mem_write  <= mw_d;
        funct3     <= f3;
        branch     <= br_d;
        jump       <= jp_d;
        target     <= tgt_d;
        illegal    <= !legal;
      end
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b, store_data, target;
  logic [3:0]  alu_sel;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  rv_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel), .alu_a(alu_a),
    .alu_b(alu_b), .store_data(store_data), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .branch(branch),
    .jump(jump), .target(target), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic        br, jp;
    logic [31:0] tg;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   acc_now = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: mnemonic-level view of RV32I, results from plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, pc_, r1, r2);
    exp_t e;
    logic [3:0]  tbl [8] = '{4'd0, 4'd5, 4'd9, 4'd10, 4'd4, 4'd6, 4'd3, 4'd2};
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] ii, is, ib, ij, iu;
    bit ok = 1;
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    iu = ins & 32'hFFFF_F000;
    e = '0;
    e.f3 = f3;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.rw = 1;
        if (f7 == 0) e.sel = tbl[f3];
        else if (f7 == 7'h20 && f3 == 0) e.sel = 1;
        else if (f7 == 7'h20 && f3 == 5) e.sel = 7;
        else ok = 0;
        if (f3 == 1 || f3 == 5) e.b = r2 % 32;
      end
      7'h13: begin
        e.a = r1; e.b = ii; e.rw = 1; e.sel = tbl[f3];
        if (f3 == 1) begin ok = (f7 == 0); e.b = 32'(ins[24:20]); end
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20);
          e.sel = (f7 == 7'h20) ? 4'd7 : 4'd6;
          e.b = 32'(ins[24:20]);
        end
      end
      7'h03: begin
        e.a = r1; e.b = ii; e.mr = 1; e.rw = 1;
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        e.a = r1; e.b = is; e.mw = 1; e.sd = r2; e.rd = 0; ok = (f3 < 3);
      end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1; e.rd = 0; e.tg = pc_ + ib;
        e.sel = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd9 : 4'd10;
        ok = !(f3 == 2 || f3 == 3);
      end
      7'h37: begin e.b = iu; e.rw = 1; end
      7'h17: begin e.a = pc_; e.b = iu; e.rw = 1; end
      7'h6f: begin e.a = pc_; e.b = 4; e.jp = 1; e.rw = 1; e.tg = pc_ + ij; end
      7'h67: begin
        e.a = pc_; e.b = 4; e.jp = 1; e.rw = 1;
        e.tg = (r1 + ii) - ((r1 + ii) % 2);
        ok = (f3 == 0);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0; e.ill = 1; e.sel = 4'hF;
    end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  // One cycle of stimulus, issued at a falling edge; the accept decision is judged just after.
  task automatic drive(input bit v, input logic [31:0] ins, pc_, r1, r2, input bit ordy,
                       input bit fl);
    bit exp_rdy;
    in_valid = v; instr = ins; pc = pc_; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (sb.size() == 0 || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc_now = v && exp_rdy;
    if (acc_now) sb.push_back(model(ins, pc_, r1, r2));
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h00};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k != 9) w[6:0] = opcs[k];
    if (k <= 1 && $urandom_range(0, 3) != 3) w[31:25] = f7s[$urandom_range(0, 3)];
    if (k == 8 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
    return w;
  endfunction

  task automatic drive_rnd(input bit v, input bit ordy, input bit fl);
    logic [31:0] w = rnd_instr();
    logic [31:0] r1 = (w[19:15] == 0) ? 32'd0 : $urandom;
    logic [31:0] r2 = (w[24:20] == 0) ? 32'd0 : $urandom;
    drive(v, w, {$urandom} & 32'hFFFF_FFFC, r1, r2, ordy, fl);
  endtask

  // Monitor: compares the presented entry to the scoreboard head every cycle, so a stalled
  // entry is checked for stability on each cycle it is held.
  always begin : monitor
    int   n;
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      n = sb.size() - int'(acc_now);
      check("out_valid", 32'(out_valid), 32'(n > 0));
      if (n > 0 && out_valid) begin
        e = sb[0];
        check("alu_sel", 32'(alu_sel), 32'(e.sel));
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("store_data", store_data, e.sd);
        check("reg_write", 32'(reg_write), 32'(e.rw));
        check("mem_read", 32'(mem_read), 32'(e.mr));
        check("mem_write", 32'(mem_write), 32'(e.mw));
        check("branch", 32'(branch), 32'(e.br));
        check("jump", 32'(jump), 32'(e.jp));
        check("target", target, e.tg);
        check("illegal", 32'(illegal), 32'(e.ill));
        if (!e.ill) begin
          check("rd", 32'(rd), 32'(e.rd));
          check("funct3", 32'(funct3), 32'(e.f3));
        end
      end
      if (n > 0 && (out_ready || flush)) void'(sb.pop_front());
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst alu_sel", 32'(alu_sel), 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst target", target, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Directed encodings.
    drive(1, 32'hFFF0_0093, 32'h0, 32'h0, 32'h0, 1, 0);            // addi x1,x0,-1
    check("addi alu_b", alu_b, 32'hFFFF_FFFF);
    check("addi rd", 32'(rd), 32'd1);
    drive(1, 32'h4020_D1B3, 32'h4, 32'h8000_0000, 32'h24, 1, 0);   // sra x3,x1,x2
    check("sra alu_sel", 32'(alu_sel), 32'b0111);
    check("sra alu_b", alu_b, 32'h4);
    drive(1, 32'h0020_E463, 32'h100, 32'h5, 32'h7, 1, 0);          // bltu x1,x2,+8
    check("bltu target", target, 32'h108);
    check("bltu alu_sel", 32'(alu_sel), 32'b1010);
    drive(1, 32'h0220_8033, 32'h104, 32'h5, 32'h7, 1, 0);          // mul -> illegal
    check("mul illegal", 32'(illegal), 32'd1);
    check("mul alu_sel", 32'(alu_sel), 32'hF);
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Backpressure: A accepted, B blocked for three stalled cycles, then drain+accept.
    drive(1, 32'h0010_0113, 32'h200, 32'h0, 32'h0, 0, 0);          // addi x2,x0,1
    repeat (3) drive(1, 32'h0020_81B3, 32'h204, 32'h11, 32'h22, 0, 0);
    drive(1, 32'h0020_81B3, 32'h204, 32'h11, 32'h22, 1, 0);        // add x3,x1,x2
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    check("bp second valid", 32'(out_valid), 32'd1);
    check("bp second alu_a", alu_a, 32'h11);
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Flush while holding an entry with a new instruction offered.
    drive(1, 32'h0050_0293, 32'h300, 32'h0, 32'h0, 0, 0);          // addi x5,x0,5
    drive(1, 32'h0060_0313, 32'h304, 32'h0, 32'h0, 1, 1);          // flushed, not taken
    check("flush out_valid", 32'(out_valid), 32'd0);
    drive(1, 32'h0060_0313, 32'h304, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Asynchronous reset during a stall.
    drive(1, 32'h0070_0393, 32'h400, 32'h0, 32'h0, 0, 0);
    in_valid = 0; out_ready = 0; flush = 0; acc_now = 0;
    #3 rst_n = 0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst alu_sel", 32'(alu_sel), 32'd0);
    sb.delete();
    rst_n = 1;
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      drive_rnd($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    repeat (3) drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- RV32I decode stage that produces the operation select and operand pair consumed by the combinational 32-bit ALU, plus control for memory, branch, jump and writeback.
- Sits between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and holds the decoded result in a single-entry output register.
- Register-file read data arrives combinationally in the same cycle as the instruction.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kills the held entry; no accept this cycle
- in_valid  in  1  instr/pc/rs1_data/rs2_data valid
- in_ready  out  1  stage can accept
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register read port 1 (x0 reads 0)
- rs2_data  in  32  register read port 2
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute consumes the entry
- alu_sel  out  4  ALU op: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1001 slt, 1010 sltu, 1111 zero
- alu_a, alu_b  out  32 each  ALU operands
- store_data  out  32  rs2_data for stores, else 0
- rd  out  5  destination register
- reg_write  out  1  writeback enable
- mem_read, mem_write  out  1 each  load/store
- funct3  out  3  instr[14:12], used for memory size and branch sense
- branch, jump  out  1 each  control-flow class
- target  out  32  branch/jump target
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n=0): out_valid=0 and every registered output is 0 (alu_sel=0000). in_ready=1 once out of reset.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready; decoded values are registered and out_valid=1 the next cycle (latency 1).
  - When out_valid && out_ready && no accept: out_valid goes to 0.
  - While out_valid && !out_ready, all outputs hold stable.
  - Drain and accept in the same cycle give back-to-back valid entries.
- Flush: out_valid goes to 0 next cycle. Flush overrides out_ready and in_valid.
- OP (0110011), funct7 0000000/0100000:
  - Functions: add/sub, sll, slt, sltu, xor, srl/sra, or, and.
  - alu_a=rs1_data, alu_b=rs2_data.
  - For shifts, alu_b={27'b0, rs2_data[4:0]}, because the ALU shifts by the full operand.
  - funct7 0100000 is legal only with funct3 000 and 101. Any other funct7 (including 0000001) is illegal.
- OP-IMM (0010011):
  - alu_b = sign-extended I-immediate.
  - Shifts: alu_b = {27'b0, instr[24:20]}.
  - SLLI/SRLI require funct7=0000000 and SRAI requires 0100000; otherwise illegal.
  - There is no SUBI.
- LUI: alu_sel=add, alu_a=0, alu_b={instr[31:12],12'b0}.
- AUIPC: alu_sel=add, alu_a=pc, alu_b={instr[31:12],12'b0}.
- LOAD: add, rs1+imm_I, mem_read=1, reg_write=1. funct3 011/110/111 is illegal.
- STORE: add, rs1+imm_S, mem_write=1, store_data=rs2_data, reg_write=0. funct3 ≥011 is illegal.
- BRANCH: alu_a=rs1_data, alu_b=rs2_data, branch=1, target=pc+imm_B, reg_write=0.
  - BEQ/BNE use sub.
  - BLT/BGE use slt.
  - BLTU/BGEU use sltu.
  - funct3 010/011 is illegal.
- JAL: add, alu_a=pc, alu_b=4, jump=1, reg_write=1, target=pc+imm_J.
- JALR: funct3 must be 000. ALU operands as JAL; target=(rs1_data+imm_I)&~1.
- reg_write is forced to 0 when rd=0.
- Illegal or unknown opcode:
  - Entry is still passed through with illegal=1, alu_sel=1111, alu_a=alu_b=0.
  - reg_write, mem_read, mem_write, branch and jump are all 0.
- Fields not defined for an instruction are driven to 0: rd for stores/branches, target for non-control-flow, store_data for non-stores.
- Additions wrap modulo 2^32.
- Reset asserted mid-stall discards the entry immediately (out_valid=0 without waiting for a clock).

Test Plan:
- ADDI x1,x0,-1:
  - Stimulus: 0xFFF00093, rs1_data=0, out_ready=1.
  - Required: next cycle out_valid=1, alu_sel=0000, alu_a=0, alu_b=0xFFFFFFFF, rd=1, reg_write=1, illegal=0.
- SRA x3,x1,x2:
  - Stimulus: 0x4020D1B3, rs1_data=0x80000000, rs2_data=0x00000024.
  - Required: alu_sel=0111, alu_a=0x80000000, alu_b=0x00000004, rd=3.
- BLTU x1,x2,+8:
  - Stimulus: 0x0020E463, pc=0x100.
  - Required: alu_sel=1010, branch=1, target=0x00000108, funct3=110, reg_write=0.
- MUL x0,x1,x2:
  - Stimulus: 0x02208033.
  - Required: illegal=1, alu_sel=1111, reg_write=0, out_valid=1.
- Backpressure:
  - Stimulus: two back-to-back instructions with out_ready=0 for 3 cycles.
  - Required: first entry held bit-stable, in_ready=0 during the stall, second instruction not accepted.
  - Then out_ready=1: second entry valid the following cycle with no bubble, and no entry lost or duplicated.
- Flush and reset:
  - Stimulus: flush=1 while out_valid=1 and in_valid=1.
  - Required: in_ready=0, out_valid=0 next cycle, and the instruction is accepted only after flush deasserts.
  - Stimulus: rst_n pulsed low mid-cycle during a stall.
  - Required: out_valid=0 and alu_sel=0000 immediately.
